pll_supervisor: RTL and testbench
=================================

# pll_supervisor

Lock supervisor and reset sequencer for the FIFO core's PLL. It runs on the free-running 24 MHz reference clock and drives the PLL `rst` input. It synchronises and qualifies the PLL `locked` output and releases the system reset only after lock has been stable. It re-resets the PLL on lock timeout or loss of lock, and declares a hard failure after a bounded number of retries.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 24 — width of each PLL reset pulse in refclk cycles (1 µs); must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, 240000 — maximum wait for lock after a PLL reset pulse ends (10 ms); must be ≥1.
- `LOCK_STABLE_CYCLES`, 2400 — consecutive synchronised-locked cycles required before release (100 µs); must be ≥1.
- `RETRY_MAX`, 3 — number of timeout-driven PLL re-resets allowed before FAIL; must be 1..255.

Ports:
- `refclk`  in  1 — reference clock; the only clock.
- `rst_n`  in  1 — asynchronous, active-low reset.
- `pll_locked`  in  1 — PLL lock indication; asynchronous to `refclk`.
- `pll_rst`  out  1 — active-high PLL reset.
- `sys_rst_n`  out  1 — active-low system reset, registered; downstream logic resynchronises it into the 96 MHz domain.
- `ready`  out  1 — high while in RUN.
- `fail`  out  1 — sticky; high in FAIL.
- `retry_cnt`  out  8 — timeout retries since `rst_n`, saturating at 255.
- `loss_cnt`  out  8 — lock losses seen in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser to give `lk_s`. No other logic samples `pll_locked`.
- A single down-counter is shared across states. Its width is `$clog2` of the largest of the three cycle parameters, plus 1.
- The FSM has five states; every output is registered.
  - RESET_PLL
    - `pll_rst`=1; counter loads `PLL_RST_CYCLES-1` on entry.
    - At 0 → WAIT_LOCK, counter loads `LOCK_TIMEOUT_CYCLES-1`.
  - WAIT_LOCK
    - `pll_rst`=0.
    - `lk_s`=1 → STABLE, counter loads `LOCK_STABLE_CYCLES-1`.
    - Counter at 0 with `lk_s`=0 → timeout; see Configuration.
  - STABLE
    - `lk_s`=0 → WAIT_LOCK; the timeout counter is reloaded in full.
    - Counter at 0 with `lk_s`=1 → RUN.
  - RUN
    - `sys_rst_n`=1, `ready`=1.
    - `lk_s`=0 → RESET_PLL and `loss_cnt`++. Lock loss is not a timeout: it never increments `retry_cnt` and never leads to FAIL.
  - FAIL
    - Terminal; exits only via `rst_n`.
    - `fail`=1, `pll_rst`=1 (held), `sys_rst_n`=0, `ready`=0.
- `sys_rst_n`=0 and `ready`=0 in every state except RUN.
- Simultaneous events: in the cycle where the counter reaches 0, `lk_s` takes priority. In WAIT_LOCK a lock wins over timeout; in STABLE a dropout wins over release.
- `lk_s` glitches shorter than one refclk period may be missed. This is acceptable because qualification requires sustained lock.

## Timing
- While `rst_n`=0, all outputs are held at their reset values: `pll_rst`=1, `sys_rst_n`=0, `ready`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, state RESET_PLL, synchroniser flops 0.
- After `rst_n` rises, `pll_rst` stays 1 for exactly `PLL_RST_CYCLES` rising edges.
- Latency from a rising `pll_locked` to entering STABLE is 3 edges: 2 for the synchroniser and 1 for the FSM.
- From entering STABLE to `sys_rst_n`/`ready` high is `LOCK_STABLE_CYCLES` edges; both rise on the same edge.
- From `pll_locked` falling in RUN, `sys_rst_n`/`ready` go low and `pll_rst` goes high 3 edges later, all on the same edge.
- If `rst_n` is asserted mid-sequence, all outputs return to their reset values immediately; no pending state is preserved.

## Configuration
- `PLL_SUPERVISOR_AUTO_RETRY_EN` is defined:
  - A timeout with `retry_cnt` < `RETRY_MAX` → RESET_PLL, `retry_cnt`++.
  - A timeout with `retry_cnt` = `RETRY_MAX` → FAIL.
- `PLL_SUPERVISOR_AUTO_RETRY_EN` is undefined:
  - Any timeout → FAIL directly.
  - `retry_cnt` is tied to 0.
  - Lock-loss recovery from RUN still operates.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=32, `LOCK_STABLE_CYCLES`=8, `RETRY_MAX`=2, refclk 24 MHz.
- Nominal start-up:
  - Stimulus: release `rst_n`; `pll_locked` rises 10 cycles after `pll_rst` falls.
  - Response: `pll_rst` high for exactly 4 cycles; `sys_rst_n` and `ready` rise exactly 3+8 cycles after `pll_locked` rises; both counters 0.
- Stability dropout:
  - Stimulus: `pll_locked` drops for 2 cycles during STABLE.
  - Response: no release; the 8-cycle qualification restarts on re-lock; `retry_cnt`=0.
- Timeout retries (macro defined):
  - Stimulus: `pll_locked` held 0.
  - Response: three 4-cycle `pll_rst` pulses separated by 32 cycles; `retry_cnt`=2; then `fail`=1 with `pll_rst` held 1.
- Timeout without retry (macro undefined):
  - Stimulus: `pll_locked` held 0.
  - Response: `fail`=1 after the first 32-cycle timeout; `retry_cnt`=0.
- Loss in RUN:
  - Stimulus: drop `pll_locked` while in RUN.
  - Response: `sys_rst_n`=0 and `pll_rst`=1 3 cycles later; `loss_cnt`=1; re-lock returns to RUN; `fail` stays 0.
- Async reset mid-run:
  - Stimulus: assert `rst_n`=0 while in STABLE.
  - Response: all outputs are at their reset values within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/pll_supervisor.sv
// pll_supervisor
//
// Lock supervisor and reset sequencer for the FIFO core PLL, clocked by the
// free-running reference clock. Holds the PLL in reset for a fixed pulse,
// waits for a qualified lock, then releases the system reset. The PLL is
// re-reset on lock timeout or on loss of lock in RUN. Repeated timeouts end
// in a terminal FAIL state.
//
// Build option:
//   PLL_SUPERVISOR_AUTO_RETRY_EN  defined   : a timeout re-resets the PLL up to
//                                             RETRY_MAX times before FAIL.
//                                 undefined : any timeout goes straight to FAIL
//                                             and retry_cnt is tied to 0.
//
// Ports:
//   refclk      in   reference clock (only clock)
//   rst_n       in   asynchronous active-low reset
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   pll_rst     out  active-high PLL reset
//   sys_rst_n   out  active-low system reset, registered
//   ready       out  high while in RUN
//   fail        out  high in FAIL (terminal)
//   retry_cnt   out  [7:0] timeout retries since rst_n
//   loss_cnt    out  [7:0] lock losses seen in RUN, saturating at 255
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RESET_PLL  | pll_rst asserted for PLL_RST_CYCLES
// WAIT_LOCK  | pll_rst released, waiting up to LOCK_TIMEOUT_CYCLES for lock
// STABLE     | lock seen, qualifying for LOCK_STABLE_CYCLES consecutive cycles
// RUN        | lock qualified, system reset released, ready high
// FAIL       | retries exhausted; PLL held in reset until rst_n

module pll_supervisor #(
    parameter int PLL_RST_CYCLES      = 24,
    parameter int LOCK_TIMEOUT_CYCLES = 240000,
    parameter int LOCK_STABLE_CYCLES  = 2400,
    parameter int RETRY_MAX           = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int MAX_RT  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_CYC = (MAX_RT > LOCK_STABLE_CYCLES) ? MAX_RT : LOCK_STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] RST_LOAD = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LOAD  = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LOAD = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    if (PLL_RST_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1 || LOCK_STABLE_CYCLES < 1) begin : g_bad_cycles
        $error("pll_supervisor: cycle parameters must be >= 1");
    end
    if (RETRY_MAX < 1 || RETRY_MAX > 255) begin : g_bad_retry
        $error("pll_supervisor: RETRY_MAX must be 1..255");
    end

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q, sync_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          lk_s;

`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);
    logic [7:0] retry_q, retry_d;
`endif

    // Only sync_q[0] ever sees the raw asynchronous pll_locked.
    assign sync_d = {sync_q[0], pll_locked};
    assign lk_s   = sync_q[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RESET_PLL;
            cnt_q       <= RST_LOAD;
            sync_q      <= 2'b00;
            loss_q      <= 8'd0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
            retry_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= sync_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fail_q      <= fail_d;
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Next state. lk_s is checked before the terminal count so that a lock
    // beats a timeout and a dropout beats a release in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            S_RESET_PLL: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_LOCK: begin
                if (lk_s) begin
                    state_d = S_STABLE;
                    cnt_d   = STB_LOAD;
                end else if (cnt_q == '0) begin
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
                    if (retry_q < RETRY_LIM) begin
                        state_d = S_RESET_PLL;
                        cnt_d   = RST_LOAD;
                        retry_d = retry_q + 8'd1;
                    end else begin
                        state_d = S_FAIL;
                    end
`else
                    state_d = S_FAIL;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STABLE: begin
                if (!lk_s) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = TO_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RUN: begin
                // Lock loss restarts the PLL but is not a timeout retry.
                if (!lk_s) begin
                    state_d = S_RESET_PLL;
                    cnt_d   = RST_LOAD;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_RESET_PLL;
                cnt_d   = RST_LOAD;
            end
        endcase
    end

    // Outputs decoded from the next state so they register alongside it.
    always_comb begin
        pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_n_d = (state_d == S_RUN);
        ready_d     = (state_d == S_RUN);
        fail_d      = (state_d == S_FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst_n = sys_rst_n_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign loss_cnt  = loss_q;
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
    assign retry_cnt = retry_q;
`else
    assign retry_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
`timescale 1ns/1ps
module tb_pll_supervisor;

    logic       refclk     = 1'b0;
    logic       rst_n      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fail;
    logic [7:0] retry_cnt, loss_cnt;

    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    bit  mon_en   = 1'b0;
    bit  done     = 1'b0;

    // expected output-change events: cycle, output vector, name
    int          exp_cyc_q[$];
    logic [19:0] exp_vec_q[$];
    string       exp_name_q[$];
    // direct snapshots handed to the monitor for comparison
    logic [19:0] dir_got_q[$];
    logic [19:0] dir_exp_q[$];
    string       dir_name_q[$];

    localparam logic [19:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};

    logic [19:0] outvec;
    logic [19:0] prev = RST_VEC;
    int          m_cyc;
    logic [19:0] m_vec, m_got;
    string       m_name;

    assign outvec = {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt};

    pll_supervisor #(
        .PLL_RST_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES(32),
        .LOCK_STABLE_CYCLES (8),
        .RETRY_MAX          (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #20.833 refclk = ~refclk;

    always @(posedge refclk) cyc <= cyc + 1;

    // {pll_rst, sys_rst_n, ready, fail, retry_cnt, loss_cnt}
    function automatic logic [19:0] mk(input logic pr, input logic sr, input logic rd,
                                       input logic fl, input int rt, input int ls);
        logic [7:0] r8, l8;
        r8 = rt[7:0];
        l8 = ls[7:0];
        return {pr, sr, rd, fl, r8, l8};
    endfunction

    task automatic expect_ev(input int c, input logic [19:0] v, input string n);
        exp_cyc_q.push_back(c);
        exp_vec_q.push_back(v);
        exp_name_q.push_back(n);
    endtask

    task automatic sample(input string n, input logic [19:0] x);
        dir_got_q.push_back(outvec);
        dir_exp_q.push_back(x);
        dir_name_q.push_back(n);
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // Monitor: every change of the output vector is an event popped from
    // the scoreboard and checked for both value and cycle of arrival.
    always @(negedge refclk) begin
        if (mon_en && (outvec !== prev)) begin
            checks++;
            if (exp_cyc_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h expected=no change", cyc, outvec);
            end else begin
                m_cyc  = exp_cyc_q.pop_front();
                m_vec  = exp_vec_q.pop_front();
                m_name = exp_name_q.pop_front();
                if ((m_cyc != cyc) || (m_vec !== outvec)) begin
                    failures++;
                    $display("FAIL %s got=%h at cyc %0d expected=%h at cyc %0d",
                             m_name, outvec, cyc, m_vec, m_cyc);
                end
            end
            prev = outvec;
        end
        while (dir_got_q.size() > 0) begin
            m_got  = dir_got_q.pop_front();
            m_vec  = dir_exp_q.pop_front();
            m_name = dir_name_q.pop_front();
            checks++;
            if (m_got !== m_vec) begin
                failures++;
                $display("FAIL %s got=%h expected=%h", m_name, m_got, m_vec);
            end
        end
        if (done) begin
            checks++;
            if (exp_cyc_q.size() != 0) begin
                failures++;
                $display("FAIL pending_events got=%0d missing (next %s at cyc %0d) expected=0",
                         exp_cyc_q.size(), exp_name_q[0], exp_cyc_q[0]);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        at_cyc(3);
        sample("reset_hold", RST_VEC);
        mon_en = 1'b1;

        // nominal start-up: release at cyc 3, pll_rst falls 4 edges later,
        // lock at 7+10=17, release 3+8 edges after that
        expect_ev(7,  mk(0, 0, 0, 0, 0, 0), "a_pll_rst_fall");
        expect_ev(28, mk(0, 1, 1, 0, 0, 0), "a_release");
        rst_n = 1'b1;
        at_cyc(17);
        pll_locked = 1'b1;

        // loss in RUN, then re-lock
        expect_ev(38, mk(1, 0, 0, 0, 0, 1), "b_loss_reset");
        expect_ev(42, mk(0, 0, 0, 0, 0, 1), "b_pll_rst_fall");
        expect_ev(58, mk(0, 1, 1, 0, 0, 1), "b_rerun");
        at_cyc(35);
        pll_locked = 1'b0;
        at_cyc(47);
        pll_locked = 1'b1;

        // dropout during STABLE restarts qualification (no release at 85)
        expect_ev(68, mk(1, 0, 0, 0, 0, 2), "c_loss_reset");
        expect_ev(72, mk(0, 0, 0, 0, 0, 2), "c_pll_rst_fall");
        expect_ev(92, mk(0, 1, 1, 0, 0, 2), "c_requalified_release");
        at_cyc(65);
        pll_locked = 1'b0;
        at_cyc(74);
        pll_locked = 1'b1;
        at_cyc(79);
        pll_locked = 1'b0;
        at_cyc(81);
        pll_locked = 1'b1;
        at_cyc(86);
        sample("c_no_early_release", mk(0, 0, 0, 0, 0, 2));

        // async reset while in STABLE (STABLE entered at 112)
        expect_ev(103, mk(1, 0, 0, 0, 0, 3), "d_loss_reset");
        expect_ev(107, mk(0, 0, 0, 0, 0, 3), "d_pll_rst_fall");
        at_cyc(100);
        pll_locked = 1'b0;
        at_cyc(109);
        pll_locked = 1'b1;
        at_cyc(114);
        @(posedge refclk);
        #5;
        expect_ev(cyc, RST_VEC, "d_async_reset_event");
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        #1 sample("d_async_reset_now", RST_VEC);

        // timeout with pll_locked held low
        at_cyc(120);
        expect_ev(124, mk(0, 0, 0, 0, 0, 0), "e_pll_rst_fall");
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
        expect_ev(156, mk(1, 0, 0, 0, 1, 0), "e_retry1_pulse");
        expect_ev(160, mk(0, 0, 0, 0, 1, 0), "e_retry1_fall");
        expect_ev(192, mk(1, 0, 0, 0, 2, 0), "e_retry2_pulse");
        expect_ev(196, mk(0, 0, 0, 0, 2, 0), "e_retry2_fall");
        expect_ev(228, mk(1, 0, 0, 1, 2, 0), "e_fail");
`else
        expect_ev(156, mk(1, 0, 0, 1, 0, 0), "e_fail");
`endif
        rst_n = 1'b1;

        // FAIL is terminal even once lock appears
        at_cyc(250);
        pll_locked = 1'b1;
        at_cyc(280);
`ifdef PLL_SUPERVISOR_AUTO_RETRY_EN
        sample("e_fail_held", mk(1, 0, 0, 1, 2, 0));
`else
        sample("e_fail_held", mk(1, 0, 0, 1, 0, 0));
`endif
        done = 1'b1;
    end

endmodule
